crd_hold_p: RTL and testbench
=============================

Name: crd_hold_p

Overview:
- Parametrised coordinate-hold primitive for the sparse streaming datapath.
- Takes an outer-level coordinate stream and an inner-level coordinate stream.
- Emits the inner stream unchanged, plus the outer coordinate repeated once per inner coordinate. The held stream carries the inner stream's stop/done structure.
- Generalises the fixed-width hold with parametrised token width and buffer depth, explicit stop-level checking, empty-fiber handling and a sticky protocol-error flag.

Parameters:
- DATA_W, 16: coordinate payload width; must be at least 10. Token width is DATA_W+1.
- FIFO_DEPTH, 2: depth of each input and output FIFO; at least 2; need not be a power of 2.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- flush, input, 1: synchronous clear with the same effect as rst.
- tile_en, input, 1: 0 = block idle, all readies and valids low.
- outer_in, input, DATA_W+1: outer coordinate token.
- outer_in_valid, input, 1; outer_in_ready, output, 1.
- inner_in, input, DATA_W+1: inner coordinate token.
- inner_in_valid, input, 1; inner_in_ready, output, 1.
- inner_out, output, DATA_W+1: inner tokens passed through.
- inner_out_valid, output, 1; inner_out_ready, input, 1.
- hold_out, output, DATA_W+1: held outer coordinate, or a copied control token.
- hold_out_valid, output, 1; hold_out_ready, input, 1.
- proto_err, output, 1: sticky protocol-error flag.

Behaviour:
- Token encoding:
  - Bit DATA_W = 0: data coordinate in bits [DATA_W-1:0].
  - Bit DATA_W = 1, bits[9:8] = 00: stop token S_n, with n = bits[7:0].
  - Bit DATA_W = 1, bits[9:8] = 01: done token (DATA_W=16 gives 17'h10100).
- Reset/flush: all FIFOs emptied, FSM to RUN, proto_err = 0. All valid and ready outputs are 0 in that cycle.
- Handshakes: valid/ready. A transfer occurs when both are high on a rising edge.
  - in_ready = FIFO not full and tile_en.
  - out_valid = FIFO not empty and tile_en.
  - Valid must not depend on ready.
- Processing: at most one step per cycle. A step that emits requires both output FIFOs to have space; both outputs are written in the same cycle. Each output drains independently.
- Latency: minimum 2 cycles from input acceptance to output valid. Sustained throughput is 1 token/cycle.
- FSM state RUN (h = outer FIFO head, i = inner FIFO head, both must be present):
  - i = data c, h = data o: emit (inner c, hold o); pop inner only.
  - i = S_n, h = data o: emit (S_n, S_n); pop both. If n ≥ 1, store n and go to OSTOP; else stay in RUN.
  - i = done, h = done: emit (done, done); pop both; stay in RUN, ready for the next tile.
  - i = data, h = stop or done: set proto_err; pop inner; no emit.
  - i = stop or done, h = stop, or any done/non-done mismatch: set proto_err; pop both; no emit.
- FSM state OSTOP (needs h only):
  - h = S_(n-1): pop; back to RUN; no emit.
  - Otherwise: set proto_err; pop; back to RUN.
- Empty fiber: inner S_n arriving directly while h holds a data coordinate is legal. The outer coordinate is consumed with no data emitted.
- Simultaneous push and pop on the same FIFO when full: the pop frees space, so the push is accepted the same cycle (ready = not full or popping).
- Reset or flush mid-stream discards all buffered tokens and the FSM context. Reset takes priority over flush, and both take priority over all handshakes.
- tile_en = 0: FSM frozen, FIFO contents retained.

Test Plan:
- Basic hold:
  - Stimulus: outer = [5, S0, D]; inner = [1, 3, 7, S1, D].
  - Required: inner_out = [1, 3, 7, S1, D]; hold_out = [5, 5, 5, S1, D]; proto_err = 0.
- Two fibers with one empty:
  - Stimulus: outer = [2, 4, S0, D]; inner = [0, S0, S1, D].
  - Required: hold_out = [2, S0, S1, D]; inner_out = [0, S0, S1, D].
  - Required: the outer 4 is consumed silently; proto_err = 0.
- Backpressure:
  - Stimulus: as the basic-hold case, with hold_out_ready toggling every cycle and inner_out_ready held low for 5 cycles.
  - Required: identical output sequences, no loss or duplication; outer_in_ready falls once FIFO_DEPTH tokens are queued.
- Throughput:
  - Stimulus: inner = 8 coordinates + S0 + D with all readies high.
  - Required: the first output valid 2 cycles after the first accept; then 1 token/cycle.
- Protocol error:
  - Stimulus: outer = [S0, D]; inner = [9, S0, D].
  - Required: proto_err rises after inner 9 is dropped and stays 1 until rst.
  - Required: rst = 1 for one cycle clears proto_err and all valids.
- Flush mid-stream:
  - Stimulus: assert flush after 3 inner tokens are accepted, then replay the basic-hold case.
  - Required: no stale tokens appear; output exactly as in the basic-hold case.

Source files
------------

// File: rtl/crd_hold_p.sv
// Coordinate-hold primitive: passes the inner coordinate stream through and repeats
// the outer coordinate once per inner token, with stop-level checking and a sticky error flag.

module crd_hold_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// state | meaning
// RUN   | pair inner head with outer head; emit or flag errors
// OSTOP | inner closed a fiber at level n>=1; outer must now show S_(n-1)
module crd_hold_p #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            tile_en,
  input  logic [DATA_W:0] outer_in,
  input  logic            outer_in_valid,
  output logic            outer_in_ready,
  input  logic [DATA_W:0] inner_in,
  input  logic            inner_in_valid,
  output logic            inner_in_ready,
  output logic [DATA_W:0] inner_out,
  output logic            inner_out_valid,
  input  logic            inner_out_ready,
  output logic [DATA_W:0] hold_out,
  output logic            hold_out_valid,
  input  logic            hold_out_ready,
  output logic            proto_err
);
  typedef enum logic {RUN, OSTOP} state_t;

  state_t          state;
  logic [7:0]      stop_n;
  logic            clr, active;
  logic [DATA_W:0] h, i, hold_val;
  logic            o_full, o_empty, i_full, i_empty;
  logic            io_full, io_empty, ho_full, ho_empty;
  logic            o_pop, i_pop, io_pop, ho_pop, emit, space;
  logic            set_err, go_ostop, go_run;
  logic            h_ctl, h_stop, h_done, i_ctl, i_stop, i_done;

  assign clr    = rst | flush;
  assign active = tile_en & ~clr;

  assign outer_in_ready  = active & (~o_full | o_pop);
  assign inner_in_ready  = active & (~i_full | i_pop);
  assign inner_out_valid = active & ~io_empty;
  assign hold_out_valid  = active & ~ho_empty;
  assign io_pop = inner_out_valid & inner_out_ready;
  assign ho_pop = hold_out_valid & hold_out_ready;
  assign space  = (~io_full | io_pop) & (~ho_full | ho_pop);

  assign h_ctl  = h[DATA_W];
  assign h_stop = h_ctl & (h[9:8] == 2'b00);
  assign h_done = h_ctl & (h[9:8] == 2'b01);
  assign i_ctl  = i[DATA_W];
  assign i_stop = i_ctl & (i[9:8] == 2'b00);
  assign i_done = i_ctl & (i[9:8] == 2'b01);

  always_comb begin
    o_pop    = 1'b0;
    i_pop    = 1'b0;
    emit     = 1'b0;
    hold_val = i;
    set_err  = 1'b0;
    go_ostop = 1'b0;
    go_run   = 1'b0;
    if (active) begin
      case (state)
        RUN: if (!o_empty && !i_empty) begin
          if (!i_ctl && !h_ctl) begin
            if (space) begin
              emit     = 1'b1;
              hold_val = h;
              i_pop    = 1'b1;
            end
          end else if (i_stop && !h_ctl) begin
            if (space) begin
              emit     = 1'b1;
              i_pop    = 1'b1;
              o_pop    = 1'b1;
              go_ostop = |i[7:0];
            end
          end else if (i_done && h_done) begin
            if (space) begin
              emit  = 1'b1;
              i_pop = 1'b1;
              o_pop = 1'b1;
            end
          end else if (!i_ctl) begin
            set_err = 1'b1;
            i_pop   = 1'b1;
          end else begin
            set_err = 1'b1;
            i_pop   = 1'b1;
            o_pop   = 1'b1;
          end
        end
        OSTOP: if (!o_empty) begin
          o_pop   = 1'b1;
          go_run  = 1'b1;
          set_err = ~(h_stop && (h[7:0] == stop_n - 8'd1));
        end
        default: go_run = 1'b1;
      endcase
    end
  end

  // Reset and flush have identical effect, so one clear branch serves both.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= RUN;
      stop_n    <= '0;
      proto_err <= 1'b0;
    end else begin
      if (set_err) proto_err <= 1'b1;
      if (go_ostop) begin
        state  <= OSTOP;
        stop_n <= i[7:0];
      end else if (go_run) begin
        state <= RUN;
      end
    end
  end

  crd_hold_fifo #(.W(DATA_W+1), .DEPTH(FIFO_DEPTH)) u_outer_fifo (
    .clk(clk), .clr(clr), .push(outer_in_valid & outer_in_ready), .pop(o_pop),
    .din(outer_in), .dout(h), .full(o_full), .empty(o_empty));

  crd_hold_fifo #(.W(DATA_W+1), .DEPTH(FIFO_DEPTH)) u_inner_fifo (
    .clk(clk), .clr(clr), .push(inner_in_valid & inner_in_ready), .pop(i_pop),
    .din(inner_in), .dout(i), .full(i_full), .empty(i_empty));

  crd_hold_fifo #(.W(DATA_W+1), .DEPTH(FIFO_DEPTH)) u_inner_out_fifo (
    .clk(clk), .clr(clr), .push(emit), .pop(io_pop),
    .din(i), .dout(inner_out), .full(io_full), .empty(io_empty));

  crd_hold_fifo #(.W(DATA_W+1), .DEPTH(FIFO_DEPTH)) u_hold_out_fifo (
    .clk(clk), .clr(clr), .push(emit), .pop(ho_pop),
    .din(hold_val), .dout(hold_out), .full(ho_full), .empty(ho_empty));
endmodule

// File: tb/tb_crd_hold_p.sv
// Directed bench for crd_hold_p: hand-built token streams, collected outputs
// compared against hand-computed sequences.

module tb_crd_hold_p;
  typedef logic [16:0] tok_t;
  typedef tok_t tok_q_t[$];

  logic clk = 1'b0;
  logic rst, flush, tile_en;
  tok_t outer_in, inner_in;
  logic outer_in_valid, outer_in_ready, inner_in_valid, inner_in_ready;
  tok_t inner_out, hold_out;
  logic inner_out_valid, inner_out_ready, hold_out_valid, hold_out_ready;
  logic proto_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int in_acc_cnt, first_acc, first_ov, last_ot;
  int istall = 0;
  bit tgl_hold = 0;
  bit saw_ofull;
  tok_q_t oq, iq, iout, hout, e_in, e_ho;

  always #5 clk = ~clk;

  crd_hold_p #(.DATA_W(16), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .tile_en(tile_en),
    .outer_in(outer_in), .outer_in_valid(outer_in_valid), .outer_in_ready(outer_in_ready),
    .inner_in(inner_in), .inner_in_valid(inner_in_valid), .inner_in_ready(inner_in_ready),
    .inner_out(inner_out), .inner_out_valid(inner_out_valid), .inner_out_ready(inner_out_ready),
    .hold_out(hold_out), .hold_out_valid(hold_out_valid), .hold_out_ready(hold_out_ready),
    .proto_err(proto_err));

  function automatic tok_t dt(input int c);
    return {1'b0, 16'(c)};
  endfunction
  function automatic tok_t st(input int n);
    return {1'b1, 8'h00, 8'(n)};
  endfunction
  localparam tok_t DN = 17'h10100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag, input tok_q_t got, input tok_q_t exp);
    check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int k = 0; k < got.size() && k < exp.size(); k++)
      check($sformatf("%s[%0d]", tag, k), 32'(got[k]), 32'(exp[k]));
  endtask

  task automatic drive();
    outer_in_valid = (oq.size() > 0);
    outer_in       = (oq.size() > 0) ? oq[0] : '0;
    inner_in_valid = (iq.size() > 0);
    inner_in       = (iq.size() > 0) ? iq[0] : '0;
  endtask

  task automatic step();
    bit o_acc, i_acc;
    @(negedge clk);
    o_acc = outer_in_valid && outer_in_ready;
    i_acc = inner_in_valid && inner_in_ready;
    if (i_acc) begin
      in_acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (inner_out_valid && first_ov < 0) first_ov = cyc;
    if (inner_out_valid && inner_out_ready) begin
      iout.push_back(inner_out);
      last_ot = cyc;
    end
    if (hold_out_valid && hold_out_ready) hout.push_back(hold_out);
    if (!outer_in_ready && tile_en && !rst && !flush) saw_ofull = 1;
    @(posedge clk);
    #1;
    cyc++;
    if (o_acc) void'(oq.pop_front());
    if (i_acc) void'(iq.pop_front());
    if (tgl_hold) hold_out_ready = ~hold_out_ready;
    if (istall > 0) begin
      istall--;
      inner_out_ready = (istall == 0);
    end
    drive();
  endtask

  task automatic run_until(input string tag, input int ni, input int nh, input int budget);
    int n = 0;
    while (!(iout.size() >= ni && hout.size() >= nh && oq.size() == 0 && iq.size() == 0)
           && n < budget) begin
      step();
      n++;
    end
    check({tag, "_complete"}, 32'(n < budget), 32'd1);
    repeat (4) step();
  endtask

  task automatic clear_run();
    oq.delete(); iq.delete(); iout.delete(); hout.delete();
    in_acc_cnt = 0; first_acc = -1; first_ov = -1; last_ot = -1;
    saw_ofull = 0;
  endtask

  initial begin
    rst = 1; flush = 0; tile_en = 1;
    inner_out_ready = 1; hold_out_ready = 1;
    clear_run();
    drive();

    // reset cycle: everything quiet
    @(negedge clk);
    check("rst_outer_ready", 32'(outer_in_ready), 32'd0);
    check("rst_inner_ready", 32'(inner_in_ready), 32'd0);
    check("rst_valids", 32'({inner_out_valid, hold_out_valid}), 32'd0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("post_rst_err", 32'(proto_err), 32'd0);
    check("post_rst_readies", 32'({outer_in_ready, inner_in_ready}), 32'd3);
    tile_en = 0;
    #1 check("tile_off_readies", 32'({outer_in_ready, inner_in_ready}), 32'd0);
    tile_en = 1;
    @(posedge clk); #1;

    // basic hold
    clear_run();
    oq = '{dt(5), st(0), DN};
    iq = '{dt(1), dt(3), dt(7), st(1), DN};
    drive();
    run_until("basic", 5, 5, 60);
    e_in = '{dt(1), dt(3), dt(7), st(1), DN};
    e_ho = '{dt(5), dt(5), dt(5), st(1), DN};
    check_seq("basic_inner", iout, e_in);
    check_seq("basic_hold", hout, e_ho);
    check("basic_err", 32'(proto_err), 32'd0);

    // two fibers, second empty
    clear_run();
    oq = '{dt(2), dt(4), st(0), DN};
    iq = '{dt(0), st(0), st(1), DN};
    drive();
    run_until("fib", 4, 4, 60);
    e_in = '{dt(0), st(0), st(1), DN};
    e_ho = '{dt(2), st(0), st(1), DN};
    check_seq("fib_inner", iout, e_in);
    check_seq("fib_hold", hout, e_ho);
    check("fib_err", 32'(proto_err), 32'd0);

    // backpressure
    clear_run();
    oq = '{dt(5), st(0), DN};
    iq = '{dt(1), dt(3), dt(7), st(1), DN};
    inner_out_ready = 0; istall = 5; tgl_hold = 1;
    drive();
    run_until("bp", 5, 5, 100);
    tgl_hold = 0; hold_out_ready = 1; inner_out_ready = 1;
    e_in = '{dt(1), dt(3), dt(7), st(1), DN};
    e_ho = '{dt(5), dt(5), dt(5), st(1), DN};
    check_seq("bp_inner", iout, e_in);
    check_seq("bp_hold", hout, e_ho);
    check("bp_outer_ready_fell", 32'(saw_ofull), 32'd1);
    check("bp_err", 32'(proto_err), 32'd0);

    // throughput
    clear_run();
    oq = '{dt(11), DN};
    e_in.delete(); e_ho.delete();
    for (int k = 0; k < 8; k++) begin
      iq.push_back(dt(3 * k));
      e_in.push_back(dt(3 * k));
      e_ho.push_back(dt(11));
    end
    iq.push_back(st(0)); iq.push_back(DN);
    e_in.push_back(st(0)); e_in.push_back(DN);
    e_ho.push_back(st(0)); e_ho.push_back(DN);
    drive();
    run_until("tput", 10, 10, 60);
    check_seq("tput_inner", iout, e_in);
    check_seq("tput_hold", hout, e_ho);
    check("tput_latency", 32'(first_ov - first_acc), 32'd2);
    check("tput_rate", 32'(last_ot - first_ov), 32'd9);

    // protocol error
    clear_run();
    oq = '{st(0), DN};
    iq = '{dt(9), st(0), DN};
    drive();
    run_until("perr", 1, 1, 60);
    e_in = '{DN};
    e_ho = '{DN};
    check_seq("perr_inner", iout, e_in);
    check_seq("perr_hold", hout, e_ho);
    check("perr_set", 32'(proto_err), 32'd1);
    repeat (3) step();
    check("perr_sticky", 32'(proto_err), 32'd1);
    rst = 1;
    @(negedge clk);
    check("perr_rst_valids", 32'({inner_out_valid, hold_out_valid, inner_in_ready}), 32'd0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("perr_rst_clear", 32'(proto_err), 32'd0);
    @(posedge clk); #1;

    // flush mid-stream
    clear_run();
    oq = '{dt(5), st(0), DN};
    iq = '{dt(1), dt(3), dt(7), st(1), DN};
    drive();
    for (int n = 0; n < 40 && in_acc_cnt < 3; n++) step();
    check("flush_three_accepted", 32'(in_acc_cnt >= 3), 32'd1);
    flush = 1;
    outer_in_valid = 0; inner_in_valid = 0;
    @(negedge clk);
    check("flush_valids", 32'({inner_out_valid, hold_out_valid, outer_in_ready}), 32'd0);
    @(posedge clk); #1 flush = 0;
    clear_run();
    oq = '{dt(5), st(0), DN};
    iq = '{dt(1), dt(3), dt(7), st(1), DN};
    drive();
    run_until("flush", 5, 5, 60);
    e_in = '{dt(1), dt(3), dt(7), st(1), DN};
    e_ho = '{dt(5), dt(5), dt(5), st(1), DN};
    check_seq("flush_inner", iout, e_in);
    check_seq("flush_hold", hout, e_ho);
    check("flush_err", 32'(proto_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
